// File: rtl/image_streamer_if.sv
// Bus bundle for image_streamer: host buffer writes, run control, pixel stream
// toward conv1_layer and the comparator result return path.
interface image_streamer_if #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned ADDR_BITS = 10
);
  logic                 wr_en;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [DATA_BITS-1:0] wr_data;
  logic                 start;
  logic                 result_valid_in;
  logic [3:0]           decision_in;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 busy;
  logic [3:0]           result;
  logic                 done;
  logic                 error;

  // Host / environment side
  modport master (
    output wr_en, wr_addr, wr_data, start, result_valid_in, decision_in,
    input  data_out, data_valid, busy, result, done, error
  );

  // Streamer side
  modport slave (
    input  wr_en, wr_addr, wr_data, start, result_valid_in, decision_in,
    output data_out, data_valid, busy, result, done, error
  );
endinterface

// File: rtl/image_streamer.sv
// Pixel source for the CNN pipeline: holds one image in a local buffer, streams
// it one pixel per clock on start, then waits for the comparator decision or
// times out.
module image_streamer #(
  parameter int unsigned IMG_PIXELS     = 784,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned ADDR_BITS      = 10,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic            clk,
  input  logic            rst_n,
  image_streamer_if.slave bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
  // One extra bit so the read pointer can hold IMG_PIXELS itself.
  localparam logic [ADDR_BITS:0] PixCnt  = (ADDR_BITS + 1)'(IMG_PIXELS);
  localparam logic [CntW-1:0]    TermCnt = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StStream, StWaitRes, StDone} state_e;

  state_e               state_q, state_d;
  logic [ADDR_BITS:0]   rd_q, rd_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic [3:0]           result_q, result_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic                 captured_q, captured_d;

  logic [DATA_BITS-1:0] mem_q [IMG_PIXELS];
  logic                 wr_fire;

  // Host writes land only while idle and inside the image; out-of-range drops.
  assign wr_fire = rst_n && (state_q == StIdle) && bus.wr_en && ({1'b0, bus.wr_addr} < PixCnt);

  // Image buffer; deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Next-state and registered-output logic for the run sequencer.
  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    data_out_d = data_out_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    result_d   = result_q;
    done_d     = 1'b0;
    error_d    = error_q;
    captured_d = captured_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d    = StStream;
          rd_d       = '0;
          error_d    = 1'b0;
          result_d   = 4'h0;
          captured_d = 1'b0;
          busy_d     = 1'b1;
        end
      end

      StStream: begin
        // Only the first early decision counts; later pulses are ignored.
        if (bus.result_valid_in && !captured_q) begin
          result_d   = bus.decision_in;
          captured_d = 1'b1;
        end
        if (rd_q < PixCnt) begin
          data_out_d = mem_q[rd_q[ADDR_BITS-1:0]];
          valid_d    = 1'b1;
          rd_d       = rd_q + 1'b1;
        end else begin
          data_out_d = '0;
          valid_d    = 1'b0;
          cnt_d      = '0;
          if (captured_d) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StWaitRes;
          end
        end
      end

      StWaitRes: begin
        // A result arriving on the terminal count still wins over the timeout.
        if (bus.result_valid_in) begin
          result_d = bus.decision_in;
          error_d  = 1'b0;
          state_d  = StDone;
          done_d   = 1'b1;
        end else if (cnt_q == TermCnt) begin
          result_d = 4'hF;
          error_d  = 1'b1;
          state_d  = StDone;
          done_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rd_q       <= '0;
      cnt_q      <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      result_q   <= 4'h0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      captured_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      result_q   <= result_d;
      done_q     <= done_d;
      error_q    <= error_d;
      captured_q <= captured_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.result     = result_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;

endmodule

// File: doc/image_streamer.md
Name: image_streamer

Overview:
Synthesizable pixel source for the CNN pipeline (conv1_layer → … → comparator). A host loads one 28x28 8-bit image into an internal buffer. On a start request the block streams the image one pixel per clock into conv1_layer's data_in, then waits for the comparator's valid/decision pair. It latches the class result and signals completion, or flags a timeout if no result arrives.

Parameters:
IMG_PIXELS, 784, pixels per image (one image = IMG_PIXELS consecutive beats)
DATA_BITS, 8, pixel width
ADDR_BITS, 10, buffer address width (2^ADDR_BITS >= IMG_PIXELS)
TIMEOUT_CYCLES, 4096, max cycles in WAIT_RES before error; counter width clog2(TIMEOUT_CYCLES)+1

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous, active-low reset
wr_en  input  1  host buffer write strobe
wr_addr  input  ADDR_BITS  host write address
wr_data  input  DATA_BITS  host write pixel
start  input  1  request to stream the buffered image
result_valid_in  input  1  comparator valid_out
decision_in  input  4  comparator decision
data_out  output  DATA_BITS  pixel to conv1_layer data_in
data_valid  output  1  data_out holds a live pixel
busy  output  1  high whenever state != IDLE
result  output  4  latched decision; 4'hF on timeout
done  output  1  one-cycle completion pulse
error  output  1  timeout flag for the last run

Behaviour:
- Reset: the state goes to IDLE. data_out=0, data_valid=0, busy=0, result=0, done=0, error=0. The read counter and timeout counter clear. Buffer RAM contents are NOT cleared.
- Reset mid-operation: the run is aborted at the next edge, all outputs take their reset values, and no done pulse is produced. The next start streams from pixel 0.
- States: IDLE, STREAM, WAIT_RES, DONE.
- IDLE:
  - A write with wr_en=1 and wr_addr < IMG_PIXELS stores wr_data. A write with wr_addr >= IMG_PIXELS is dropped.
  - start=1 at edge E0 moves the state to STREAM, sets rd_addr=0, and clears error and result.
  - If start and wr_en are both high at E0, the write is performed. The read at E1 observes the written value.
- STREAM:
  - At edge E(k+1) the block sets data_out=mem[k] and data_valid=1, for k = 0..IMG_PIXELS-1.
  - Result: exactly IMG_PIXELS consecutive valid beats with no gaps. The first valid pixel appears one edge after the start edge.
  - At edge E(IMG_PIXELS+1) the block sets data_valid=0 and data_out=0, and moves to WAIT_RES with the timeout counter at 0.
- WAIT_RES:
  - The timeout counter increments every cycle.
  - result_valid_in=1 latches decision_in into result, leaves error=0, and moves to DONE.
  - If the counter reaches TIMEOUT_CYCLES-1 with no result, the block sets result=4'hF and error=1, and moves to DONE.
  - If result_valid_in and the terminal count occur in the same cycle, the result wins.
- Early result during STREAM: the first result_valid_in is latched into result and a "captured" flag is set. Later pulses are ignored. Streaming still completes all beats. After the last beat the block goes directly to DONE and skips WAIT_RES.
- DONE: done=1 for exactly one cycle, then the state returns to IDLE. result and error hold until the next accepted start.
- Busy behaviour:
  - start while busy is ignored, with no restart and no queueing.
  - wr_en while busy is ignored, so the buffer is stable during a run.
- result_valid_in in IDLE or DONE is ignored.
- Total run length with no early result: 1 + IMG_PIXELS + (result latency or TIMEOUT_CYCLES) + 1 cycles of busy.

Test Plan:
- Load pixel k = k mod 256 for k = 0..783, then pulse start → data_valid high for exactly 784 consecutive cycles starting one edge after start. data_out follows 0..255 repeating and ends at 783 mod 256 = 0x0F. busy stays high throughout.
- Pulse result_valid_in with decision_in=7 100 cycles after streaming ends → result=7, error=0, done high for one cycle, busy low the following cycle.
- TIMEOUT_CYCLES=50 with no result → done fires 50 cycles after entering WAIT_RES, with result=4'hF and error=1. A subsequent start clears error to 0.
- Write 0xAA to address 5 and a write to address 900 during STREAM, then another start during STREAM → the stream is unchanged, the next run still outputs the old pixel 5, no restart occurs, and address 900 writes nothing in either state.
- Assert rst_n=0 for one cycle while pixel 300 is on data_out → data_valid=0 and busy=0 after that edge, no done pulse. A fresh start streams from pixel 0 with the buffer intact.
- Pulse result_valid_in with decision_in=3 at beat 500 during STREAM, then decision_in=9 at beat 600 → all 784 beats are still streamed, done fires one cycle after the last beat, and result=3.
